// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack for the Computer16 fetch path.
// One command per cycle: stall > load > call > ret > inc > hold; reset overrides all.
module pc_call_stack #(
  parameter int                 WIDTH        = 16,
  parameter int                 DEPTH        = 8,
  parameter logic [WIDTH-1:0]   STEP         = WIDTH'(1),
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic                         load,
  input  logic                         inc,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         stall,
  output logic [WIDTH-1:0]             out,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             full, empty;
  logic             push_en;
  logic [AW-1:0]    push_idx, pop_idx;
  logic [WIDTH-1:0] ret_addr;

  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  assign push_idx = AW'(depth_q);
  assign pop_idx  = AW'(depth_q - DW'(1));
  assign ret_addr = out_q + STEP;

  always_comb begin
    out_d   = out_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!stall) begin
      if (load) begin
        out_d = in;
      end else if (call) begin
        // The jump happens even when the push must be dropped.
        out_d = in;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          depth_d = depth_q + DW'(1);
        end
      end else if (ret) begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          out_d   = stack_q[pop_idx];
          depth_d = depth_q - DW'(1);
        end
      end else if (inc) begin
        out_d = out_q + STEP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= RESET_VECTOR;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push_en) begin
        stack_q[push_idx] <= ret_addr;
      end
    end
  end

  assign out         = out_q;
  assign depth       = depth_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed vector table, overflow/underflow sequences,
// and random commands checked against a queue-based return-stack model.
module tb_pc_call_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH+1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             load, inc, call, ret, stall;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             stack_empty, stack_full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  pc_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in(in), .load(load), .inc(inc),
    .call(call), .ret(ret), .stall(stall), .out(out), .depth(depth),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             rst, ld, in_c, cl, rt, st;
    logic [WIDTH-1:0] in_v;
    logic [WIDTH-1:0] e_out;
    int               e_depth;
    logic             e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ld, input logic ic,
                              input logic cl, input logic rt, input logic st,
                              input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] eo,
                              input int ed, input logic eov, input logic eun);
    vec_t v;
    v.rst = rst; v.ld = ld; v.in_c = ic; v.cl = cl; v.rt = rt; v.st = st;
    v.in_v = iv; v.e_out = eo; v.e_depth = ed; v.e_ovf = eov; v.e_unf = eun;
    return v;
  endfunction

  // driver
  task automatic apply(input logic rst, input logic ld, input logic ic, input logic cl,
                       input logic rt, input logic st, input logic [WIDTH-1:0] iv);
    @(negedge clock);
    reset = rst; load = ld; inc = ic; call = cl; ret = rt; stall = st; in = iv;
    @(posedge clock);
    #1;
  endtask

  // scoreboard
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [WIDTH-1:0] eo, input int ed,
                       input logic eov, input logic eun);
    cmp({nm, " out"},       32'(out),         32'(eo));
    cmp({nm, " depth"},     32'(depth),       32'(ed));
    cmp({nm, " empty"},     32'(stack_empty), 32'(ed == 0));
    cmp({nm, " full"},      32'(stack_full),  32'(ed == DEPTH));
    cmp({nm, " overflow"},  32'(overflow),    32'(eov));
    cmp({nm, " underflow"}, 32'(underflow),   32'(eun));
  endtask

  // random-phase reference model
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_ovf, m_unf;

  task automatic model_step(input logic rst, input logic ld, input logic ic, input logic cl,
                            input logic rt, input logic st, input logic [WIDTH-1:0] iv);
    logic [WIDTH-1:0] ra;
    ra = m_out + 16'd1;
    if (rst) begin
      m_out = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (st) begin
      m_out = m_out;
    end else if (ld) begin
      m_out = iv;
    end else if (cl) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(ra);
      else m_ovf = 1'b1;
      m_out = iv;
    end else if (rt) begin
      if (m_stk.size() > 0) m_out = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (ic) begin
      m_out = ra;
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0; in = '0;

    // rst ld inc call ret stall in -> out depth ovf unf
    vecs.push_back(mk(1,0,0,0,0,0, 16'd0,     16'd0,     0, 0, 0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0,0,1,0,0,0, 16'd0, 16'(k), 0, 0, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 16'd7,     16'd7,     0, 0, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 16'hFFFF,  16'hFFFF,  0, 0, 0));
    vecs.push_back(mk(0,0,1,0,0,0, 16'd0,     16'h0000,  0, 0, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 16'd3,     16'd3,     0, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0, 16'd100,   16'd100,   1, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0, 16'd200,   16'd200,   2, 0, 0));
    vecs.push_back(mk(0,0,0,0,1,0, 16'd0,     16'd101,   1, 0, 0));
    vecs.push_back(mk(0,0,0,0,1,0, 16'd0,     16'd4,     0, 0, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 16'd9,     16'd9,     0, 0, 0));
    vecs.push_back(mk(0,0,0,0,1,0, 16'd0,     16'd9,     0, 0, 1));
    vecs.push_back(mk(0,1,1,1,0,1, 16'd55,    16'd9,     0, 0, 1));
    vecs.push_back(mk(1,0,0,0,0,0, 16'd0,     16'd0,     0, 0, 0));
    vecs.push_back(mk(0,1,0,1,0,0, 16'd40,    16'd40,    0, 0, 0));
    vecs.push_back(mk(0,0,0,1,1,0, 16'd60,    16'd60,    1, 0, 0));
    vecs.push_back(mk(0,0,0,0,1,0, 16'd0,     16'd41,    0, 0, 0));
    vecs.push_back(mk(0,0,0,1,0,0, 16'd80,    16'd80,    1, 0, 0));
    vecs.push_back(mk(1,0,0,1,0,0, 16'd70,    16'd0,     0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].ld, vecs[i].in_c, vecs[i].cl, vecs[i].rt, vecs[i].st, vecs[i].in_v);
      check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_depth, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Fill the stack, overflow it, then unwind in LIFO order.
    apply(1,0,0,0,0,0, 16'd0);
    check("ovf_reset", 16'd0, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      apply(0,0,0,1,0,0, 16'(10 + k));
      check($sformatf("fill%0d", k), 16'(10 + k), k + 1, 0, 0);
    end
    apply(0,0,0,1,0,0, 16'd50);
    check("call_full", 16'd50, DEPTH, 1, 0);
    for (int k = 0; k < DEPTH; k++) begin
      // Pushed return addresses were 1, 11, 12, ..., 17.
      apply(0,0,0,0,1,0, 16'd0);
      check($sformatf("unwind%0d", k), (k == DEPTH - 1) ? 16'd1 : 16'(17 - k),
            DEPTH - 1 - k, 1, 0);
    end
    apply(0,0,0,0,1,0, 16'd0);
    check("ret_empty", 16'd1, 0, 1, 1);
    apply(0,1,1,1,1,1, 16'd123);
    check("stall_sticky", 16'd1, 0, 1, 1);
    apply(0,0,1,0,0,0, 16'd0);
    check("inc_sticky", 16'd2, 0, 1, 1);

    // Randomised commands against the reference model.
    apply(1,0,0,0,0,0, 16'd0);
    model_step(1,0,0,0,0,0, 16'd0);
    check("rand_reset", m_out, m_stk.size(), m_ovf, m_unf);
    for (int n = 0; n < 600; n++) begin
      logic r_rst, r_ld, r_ic, r_cl, r_rt, r_st;
      logic [WIDTH-1:0] r_in;
      r_rst = ($urandom_range(0, 79) == 0);
      r_st  = ($urandom_range(0, 7) == 0);
      r_ld  = ($urandom_range(0, 7) == 0);
      r_cl  = ($urandom_range(0, 2) == 0);
      r_rt  = ($urandom_range(0, 2) == 0);
      r_ic  = ($urandom_range(0, 1) == 0);
      r_in  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                          : 16'($urandom_range(0, 65535));
      apply(r_rst, r_ld, r_ic, r_cl, r_rt, r_st, r_in);
      model_step(r_rst, r_ld, r_ic, r_cl, r_rt, r_st, r_in);
      check($sformatf("rand%0d", n), m_out, m_stk.size(), m_ovf, m_unf);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised next-generation program counter for the Computer16 CPU.
- Keeps the existing load/inc/reset semantics and adds a hardware return-address stack (call/ret), a stall input, a configurable width, step and reset vector, and stack status flags.
- Sits in the CPU fetch path; its `out` drives the instruction-memory address.

Parameters:
- WIDTH, 16, bit width of `in`, `out` and every stack entry.
- DEPTH, 8, number of return-address stack entries (>=2).
- STEP, 1, increment applied by `inc` and used to form the return address.
- RESET_VECTOR, 0, value `out` takes on reset.

Ports:
- clock  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- in  input  WIDTH  jump/call target address.
- load  input  1  jump: out <= in.
- inc  input  1  advance: out <= out + STEP.
- call  input  1  push return address out+STEP, then out <= in.
- ret  input  1  pop: out <= top of stack.
- stall  input  1  freeze PC and stack this cycle.
- out  output  WIDTH  current program counter (registered).
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- stack_empty  output  1  depth == 0.
- stack_full  output  1  depth == DEPTH.
- overflow  output  1  sticky; call attempted while full.
- underflow  output  1  sticky; ret attempted while empty.

Behaviour:
- All state updates on the rising edge of clock; `out` and the flags are registered. Command sampled at edge N is visible after edge N.
- Reset (highest priority, synchronous, active-high):
  - out = RESET_VECTOR, depth = 0, overflow = 0, underflow = 0, stack_empty = 1, stack_full = 0.
  - Stack contents are don't-care after reset.
- Priority when reset = 0: stall > load > call > ret > inc > hold. Exactly one action per cycle; lower-priority inputs asserted in the same cycle are ignored.
- stall: out, stack, depth and the sticky flags all hold.
- load: out <= in; stack untouched.
- call, not full:
  - stack[depth] <= out + STEP (mod 2^WIDTH); depth += 1; out <= in.
- call, full:
  - out <= in (the jump still happens).
  - The push is dropped; stack contents and depth are unchanged.
  - overflow <= 1.
- ret, not empty: out <= stack[depth-1]; depth -= 1.
- ret, empty: out holds; depth stays 0; underflow <= 1.
- inc: out <= out + STEP, wrapping modulo 2^WIDTH (16'hFFFF + 1 -> 16'h0000). No carry or flag is produced.
- No command: out holds.
- overflow and underflow stay set until reset; stall does not clear them.
- stack_empty and stack_full are derived from the registered depth and always consistent with it.
- Reset asserted mid-sequence (for example with call in the same cycle): reset wins and the stack is emptied.
- Arithmetic is unsigned, WIDTH bits, and the carry is discarded.
- The stack is LIFO, implemented as a register array indexed by depth; there is no read latency.

Test Plan:
- reset=1 for 1 edge, then inc=1 for 5 edges -> out steps 0,1,2,3,4,5; depth=0, stack_empty=1.
- From out=5: load=1, in=7 -> out=7. Then load=1, in=16'hFFFF, then inc -> out=16'hFFFF then 16'h0000 (wrap).
- Nested calls: out=3, call in=100 -> out=100, depth=1. call in=200 -> out=200, depth=2. ret -> out=101, depth=1. ret -> out=4, depth=0.
- Overflow: 8 calls with in=10..17 -> stack_full=1, depth=8, out=17. A 9th call with in=50 -> out=50, overflow=1, depth=8. Then 8 rets return the pushed addresses in reverse order (the top is 17's predecessor+1), and the first ret yields 16+1=17.
- Underflow and stall:
  - ret on an empty stack at out=9 -> out=9, underflow=1.
  - stall=1 together with inc, load and call -> out, depth and flags unchanged.
  - A subsequent reset clears underflow and out=0.
- Simultaneous inputs and reset during a call:
  - load=1, call=1, in=40 -> out=40, depth unchanged (load wins).
  - call=1, ret=1 -> a call is performed.
  - reset=1 with call=1 -> out=RESET_VECTOR, depth=0.
